// File: rtl/flag_unit.sv
// NZCV architectural flag register with a small LIFO shadow stack that saves
// flags on exception entry and restores them on exception return.
module flag_unit #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Valid,
  input  logic       Stall,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       CondEx,
  input  logic       ExcEntry,
  input  logic       ExcReturn,
  output logic [3:0] Flags,
  output logic [3:0] SavedFlags,
  output logic [2:0] Depth,
  output logic       FlagsChanged,
  output logic       StackErr
);

  localparam logic [2:0] MaxDepth = 3'(DEPTH);

  logic [3:0] stack [DEPTH];
  logic       wr;
  logic       push;
  logic       pop;
  logic       stackFault;
  logic [3:0] top;
  logic [3:0] nextFlags;

  // ExcEntry outranks ExcReturn, and either one squashes the instruction write.
  always_comb begin
    wr         = Valid & ~Stall & CondEx & ~ExcEntry & ~ExcReturn;
    push       = ExcEntry && (Depth < MaxDepth);
    pop        = !ExcEntry && ExcReturn && (Depth != 3'd0);
    stackFault = (ExcEntry && (Depth >= MaxDepth)) ||
                 (!ExcEntry && ExcReturn && (Depth == 3'd0));

    top = 4'b0000;
    for (int i = 0; i < DEPTH; i++) begin
      if (Depth == 3'(i + 1)) top = stack[i];
    end

    nextFlags = Flags;
    if (pop) begin
      nextFlags = top;
    end else if (wr) begin
      if (FlagW[1]) nextFlags[3:2] = ALUFlags[3:2];
      if (FlagW[0]) nextFlags[1:0] = ALUFlags[1:0];
    end
  end

  assign SavedFlags = top;

  // Popped entries are cleared so an empty stack always reads back as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      Flags        <= 4'b0000;
      Depth        <= 3'd0;
      FlagsChanged <= 1'b0;
      StackErr     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= 4'b0000;
    end else begin
      Flags        <= nextFlags;
      FlagsChanged <= (nextFlags != Flags);
      if (stackFault) StackErr <= 1'b1;
      if (push) Depth <= Depth + 3'd1;
      else if (pop) Depth <= Depth - 3'd1;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (Depth == 3'(i))) stack[i] <= Flags;
        else if (pop && (Depth == 3'(i + 1))) stack[i] <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: a table of per-cycle vectors with hand-computed
// expected outputs, followed by a few hand-written multi-cycle sequences.
module tb_flag_unit;

  logic       clock;
  logic       reset;
  logic       valid;
  logic       stall;
  logic [3:0] aluFlags;
  logic [1:0] flagW;
  logic       condEx;
  logic       excEntry;
  logic       excReturn;
  logic [3:0] flags;
  logic [3:0] savedFlags;
  logic [2:0] depth;
  logic       flagsChanged;
  logic       stackErr;

  int vectorCount = 0;
  int missCount   = 0;

  typedef struct {
    logic       rst;
    logic       vld;
    logic       stl;
    logic [3:0] alu;
    logic [1:0] fw;
    logic       cex;
    logic       ent;
    logic       ret;
    logic [3:0] expFlags;
    logic [3:0] expSaved;
    logic [2:0] expDepth;
    logic       expChanged;
    logic       expErr;
  } vec_t;

  vec_t vecs[$];

  flag_unit #(.DEPTH(2)) dut (
    .clk          (clock),
    .reset        (reset),
    .Valid        (valid),
    .Stall        (stall),
    .ALUFlags     (aluFlags),
    .FlagW        (flagW),
    .CondEx       (condEx),
    .ExcEntry     (excEntry),
    .ExcReturn    (excReturn),
    .Flags        (flags),
    .SavedFlags   (savedFlags),
    .Depth        (depth),
    .FlagsChanged (flagsChanged),
    .StackErr     (stackErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    reset     = v.rst;
    valid     = v.vld;
    stall     = v.stl;
    aluFlags  = v.alu;
    flagW     = v.fw;
    condEx    = v.cex;
    excEntry  = v.ent;
    excReturn = v.ret;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    vectorCount++;
    if (flags !== v.expFlags) begin
      missCount++;
      $display("[TB] FAIL %s flags: got %b expected %b", name, flags, v.expFlags);
    end
    if (savedFlags !== v.expSaved) begin
      missCount++;
      $display("[TB] FAIL %s savedFlags: got %b expected %b", name, savedFlags, v.expSaved);
    end
    if (depth !== v.expDepth) begin
      missCount++;
      $display("[TB] FAIL %s depth: got %0d expected %0d", name, depth, v.expDepth);
    end
    if (flagsChanged !== v.expChanged) begin
      missCount++;
      $display("[TB] FAIL %s flagsChanged: got %b expected %b", name, flagsChanged, v.expChanged);
    end
    if (stackErr !== v.expErr) begin
      missCount++;
      $display("[TB] FAIL %s stackErr: got %b expected %b", name, stackErr, v.expErr);
    end
  endtask

  task automatic runVec(input string name, input vec_t v);
    applyStimulus(v);
    checkOutput(name, v);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; stall = 1'b0; aluFlags = 4'b0000;
    flagW = 2'b00; condEx = 1'b0; excEntry = 1'b0; excReturn = 1'b0;

    // rst vld stl alu fw cex ent ret | flags saved depth chg err
    vecs.push_back('{1'b1,1'b1,1'b0,4'b1111,2'b11,1'b1,1'b0,1'b0, 4'b0000,4'b0000,3'd0,1'b0,1'b0});
    vecs.push_back('{1'b1,1'b1,1'b0,4'b1111,2'b11,1'b1,1'b0,1'b0, 4'b0000,4'b0000,3'd0,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,4'b1010,2'b11,1'b1,1'b0,1'b0, 4'b1010,4'b0000,3'd0,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,4'b0101,2'b01,1'b1,1'b0,1'b0, 4'b1001,4'b0000,3'd0,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,4'b0110,2'b11,1'b0,1'b0,1'b0, 4'b1001,4'b0000,3'd0,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b1,4'b0110,2'b11,1'b1,1'b0,1'b0, 4'b1001,4'b0000,3'd0,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b0110,2'b11,1'b1,1'b0,1'b0, 4'b1001,4'b0000,3'd0,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,4'b1001,2'b11,1'b1,1'b0,1'b0, 4'b1001,4'b0000,3'd0,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,4'b0110,2'b11,1'b1,1'b1,1'b0, 4'b1001,4'b1001,3'd1,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,4'b0100,2'b11,1'b1,1'b0,1'b0, 4'b0100,4'b1001,3'd1,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,4'b1111,2'b11,1'b1,1'b0,1'b1, 4'b1001,4'b0000,3'd0,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,4'b0001,2'b11,1'b1,1'b0,1'b0, 4'b0001,4'b0000,3'd0,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b0000,2'b00,1'b0,1'b1,1'b0, 4'b0001,4'b0001,3'd1,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,4'b0010,2'b11,1'b1,1'b0,1'b0, 4'b0010,4'b0001,3'd1,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b0000,2'b00,1'b0,1'b1,1'b0, 4'b0010,4'b0010,3'd2,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,4'b0100,2'b11,1'b1,1'b0,1'b0, 4'b0100,4'b0010,3'd2,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b0000,2'b00,1'b0,1'b1,1'b0, 4'b0100,4'b0010,3'd2,1'b0,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b0000,2'b00,1'b0,1'b0,1'b1, 4'b0010,4'b0001,3'd1,1'b1,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b0000,2'b00,1'b0,1'b0,1'b1, 4'b0001,4'b0000,3'd0,1'b1,1'b1});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b0000,2'b00,1'b0,1'b0,1'b1, 4'b0001,4'b0000,3'd0,1'b0,1'b1});
    vecs.push_back('{1'b1,1'b0,1'b0,4'b0000,2'b00,1'b0,1'b0,1'b0, 4'b0000,4'b0000,3'd0,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,4'b0011,2'b11,1'b1,1'b0,1'b0, 4'b0011,4'b0000,3'd0,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b0000,2'b00,1'b0,1'b1,1'b0, 4'b0011,4'b0011,3'd1,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,4'b1100,2'b11,1'b1,1'b1,1'b1, 4'b0011,4'b0011,3'd2,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b1,1'b0,4'b1000,2'b11,1'b1,1'b0,1'b0, 4'b1000,4'b0011,3'd2,1'b1,1'b0});

    foreach (vecs[i]) runVec($sformatf("vec%0d", i), vecs[i]);

    // Reset at depth 2 with a return pending discards the pop.
    runVec("rstWithReturn", '{1'b1,1'b1,1'b0,4'b1111,2'b11,1'b1,1'b0,1'b1,
                              4'b0000,4'b0000,3'd0,1'b0,1'b0});

    // Stall blocks the instruction write but not exception entry or return.
    runVec("seqWrite",      '{1'b0,1'b1,1'b0,4'b0111,2'b11,1'b1,1'b0,1'b0,
                              4'b0111,4'b0000,3'd0,1'b1,1'b0});
    runVec("seqStallPush",  '{1'b0,1'b1,1'b1,4'b1110,2'b11,1'b1,1'b1,1'b0,
                              4'b0111,4'b0111,3'd1,1'b0,1'b0});
    runVec("seqWrite2",     '{1'b0,1'b1,1'b0,4'b1110,2'b10,1'b1,1'b0,1'b0,
                              4'b1111,4'b0111,3'd1,1'b1,1'b0});
    runVec("seqStallPop",   '{1'b0,1'b1,1'b1,4'b0000,2'b11,1'b1,1'b0,1'b1,
                              4'b0111,4'b0000,3'd0,1'b1,1'b0});
    runVec("seqPulseEnds",  '{1'b0,1'b0,1'b0,4'b0000,2'b00,1'b0,1'b0,1'b0,
                              4'b0111,4'b0000,3'd0,1'b0,1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
# flag_unit

Architectural NZCV flag register for the ARMv4 processor. It is the producer side of the condition-evaluation path. It captures ALU flags from the Execute stage under FlagW group control, gated by the condition-check result, and presents the current flags to the condition checker. It also holds a small shadow stack that saves and restores flags on exception entry and return.

## Interface
Parameters:
- DEPTH, default 2: number of shadow-stack entries (1..4).

Ports:
- clk  input  1  processor clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Valid  input  1  the Execute-stage instruction is valid.
- Stall  input  1  Execute is stalled; blocks the instruction flag write.
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the Execute instruction.
- FlagW  input  2  bit1 enables the N,Z group; bit0 enables the C,V group.
- CondEx  input  1  condition-check result for the Execute instruction.
- ExcEntry  input  1  exception entry: push the current Flags onto the shadow stack.
- ExcReturn  input  1  exception return: pop the shadow stack into Flags.
- Flags  output  4  architectural {N,Z,C,V}; drives the condition checker.
- SavedFlags  output  4  top of the shadow stack; 0000 when the stack is empty.
- Depth  output  3  number of occupied shadow entries.
- FlagsChanged  output  1  one-cycle pulse; Flags changed at the previous edge.
- StackErr  output  1  sticky error: overflow or underflow of the shadow stack.

## Operation
- Instruction write enable: `wr = Valid & ~Stall & CondEx & ~ExcEntry & ~ExcReturn`.
  - If `wr & FlagW[1]`: N,Z <= ALUFlags[3:2].
  - If `wr & FlagW[0]`: C,V <= ALUFlags[1:0].
  - Groups are independent. A group that is not enabled holds its value.
- Priority at each edge: reset > ExcEntry > ExcReturn > instruction write.
- ExcEntry:
  - If Depth < DEPTH: push the pre-edge Flags, Depth+1.
  - If the stack is full: no push, the oldest entry is kept, StackErr <= 1.
  - In both cases the pending instruction write is squashed and Flags is unchanged.
  - An ExcReturn asserted in the same cycle is ignored.
- ExcReturn, with ExcEntry low:
  - If Depth > 0: Flags <= top entry, pop, Depth-1.
  - If Depth == 0: Flags unchanged, StackErr <= 1.
  - The pending instruction write is squashed.
- Stall gates only the instruction write. ExcEntry and ExcReturn act regardless of Stall.
- The stack is LIFO. SavedFlags shows the most recent unpopped push.
- FlagsChanged <= (next Flags != current Flags). A write of identical values does not pulse.
- StackErr clears only on reset.
- There is no combinational path from any input to Flags. CondEx may be computed from Flags in the same cycle without forming a loop.

## Timing
- Reset values: Flags=0000, SavedFlags=0000, Depth=0, FlagsChanged=0, StackErr=0. All stack entries are cleared.
- Reset asserted mid-operation, at any Depth, returns everything to the reset values on that edge. Any push or pop in the same cycle is discarded.
- Write latency is 1 cycle. ALUFlags sampled at edge k are visible on Flags after edge k. The instruction in Execute during cycle k+1 evaluates its condition against them.
- ExcEntry and ExcReturn each take effect in 1 cycle. SavedFlags and Depth update at the same edge.
- FlagsChanged is high for exactly the cycle after the changing edge.
- Back-to-back ExcEntry pulses push on consecutive edges.

## Test plan
- Reset check: hold reset 2 cycles, with ALUFlags=1111, FlagW=11, Valid=1, CondEx=1 also driven.
  - Flags=0000, Depth=0, StackErr=0, FlagsChanged=0 throughout.
- Group writes: ALUFlags=1010 with FlagW=11 and CondEx=1; next cycle ALUFlags=0101 with FlagW=01.
  - Flags=1010, then Flags=1001. FlagsChanged pulses after each edge.
- Gating: Flags=1001, then FlagW=11 and ALUFlags=0110 with each of CondEx=0, Stall=1 and Valid=0 in turn.
  - Flags stays 1001 and FlagsChanged stays 0.
  - Rewriting 1001 with a valid write also gives FlagsChanged=0.
- Save/restore: Flags=1001, ExcEntry plus a valid write of 0110.
  - Write squashed, SavedFlags=1001, Depth=1.
  - Next, write 0100, giving Flags=0100. Then ExcReturn gives Flags=1001, Depth=0, SavedFlags=0000.
- Nesting and errors, DEPTH=2:
  - Push with Flags=0001, write 0010, push, write 0100, push.
  - Third push gives Depth=2 and StackErr=1.
  - Return gives Flags=0010. Return gives Flags=0001.
  - A third return leaves Flags=0001 and StackErr stays 1.
- Simultaneous events and reset:
  - ExcEntry and ExcReturn together at Depth=1: push occurs, Depth=2, Flags unchanged.
  - Reset asserted at Depth=2 with ExcReturn high: all outputs return to reset values.
